// File: rtl/scan_letter_queue.sv
// PS/2 set-2 letter front end: decodes E0/F0 prefixes, suppresses typematic
// repeats and queues one letter index per key press. Macro SCAN_TYPEMATIC_EN
// disables repeat suppression so auto-repeat pushes every make code.
module scan_letter_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic             scan_valid,
  input  logic [7:0]       scan_code,
  input  logic             out_ready,
  input  logic             clr_ovf,
  output logic             out_valid,
  output logic [4:0]       out_index,
  output logic [25:0]      out_onehot,
  output logic [PTR_W:0]   count,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXTBRK} state_e;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  state_e             state_q, state_d;
  logic [7:0]         held_code_q, held_code_d;
  logic               held_valid_q, held_valid_d;
  logic [4:0]         mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     count_q;
  logic               ovf_q;

  logic       is_letter;
  logic [4:0] letter_idx;
  logic       is_repeat;
  logic       push_req, push_ok, pop, full, drop;

  always_comb begin
    is_letter  = 1'b1;
    letter_idx = 5'd0;
    case (scan_code)
      8'h1C: letter_idx = 5'd0;   8'h32: letter_idx = 5'd1;
      8'h21: letter_idx = 5'd2;   8'h23: letter_idx = 5'd3;
      8'h24: letter_idx = 5'd4;   8'h2B: letter_idx = 5'd5;
      8'h34: letter_idx = 5'd6;   8'h33: letter_idx = 5'd7;
      8'h43: letter_idx = 5'd8;   8'h3B: letter_idx = 5'd9;
      8'h42: letter_idx = 5'd10;  8'h4B: letter_idx = 5'd11;
      8'h3A: letter_idx = 5'd12;  8'h31: letter_idx = 5'd13;
      8'h44: letter_idx = 5'd14;  8'h4D: letter_idx = 5'd15;
      8'h15: letter_idx = 5'd16;  8'h2D: letter_idx = 5'd17;
      8'h1B: letter_idx = 5'd18;  8'h2C: letter_idx = 5'd19;
      8'h3C: letter_idx = 5'd20;  8'h2A: letter_idx = 5'd21;
      8'h1D: letter_idx = 5'd22;  8'h22: letter_idx = 5'd23;
      8'h35: letter_idx = 5'd24;  8'h1A: letter_idx = 5'd25;
      default: is_letter = 1'b0;
    endcase
  end

`ifdef SCAN_TYPEMATIC_EN
  assign is_repeat = 1'b0;
`else
  assign is_repeat = held_valid_q && (scan_code == held_code_q);
`endif

  // Prefix decoder and held-key tracking; only scan_valid cycles advance it.
  always_comb begin
    state_d      = state_q;
    held_code_d  = held_code_q;
    held_valid_d = held_valid_q;
    push_req     = 1'b0;
    if (scan_valid) begin
      case (state_q)
        IDLE: begin
          if (scan_code == 8'hE0)      state_d = EXT;
          else if (scan_code == 8'hF0) state_d = BRK;
          else if (is_letter) begin
            push_req     = !is_repeat;
            held_code_d  = scan_code;
            held_valid_d = 1'b1;
          end
        end
        BRK: begin
          state_d = IDLE;
          if (held_valid_q && scan_code == held_code_q) held_valid_d = 1'b0;
        end
        EXT:     state_d = (scan_code == 8'hF0) ? EXTBRK : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign full    = (count_q == FULL_CNT);
  assign pop     = out_valid && out_ready;
  // A pop on the same edge frees the slot, so a full queue still accepts.
  assign push_ok = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      held_code_q  <= 8'h00;
      held_valid_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 5'd0;
    end else begin
      state_q      <= state_d;
      held_code_q  <= held_code_d;
      held_valid_q <= held_valid_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= letter_idx;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop)         ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

  assign out_valid  = (count_q != '0);
  assign out_index  = out_valid ? mem_q[rd_ptr_q] : 5'd0;
  assign out_onehot = out_valid ? (26'd1 << out_index) : 26'd0;
  assign count      = count_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_scan_letter_queue.sv
// Directed bench for scan_letter_queue (default build, DEPTH=4).
module tb_scan_letter_queue;

  logic        CLOCK_50 = 1'b0;
  logic        resetn = 1'b0;
  logic        scan_valid = 1'b0;
  logic [7:0]  scan_code = 8'h00;
  logic        out_ready = 1'b0;
  logic        clr_ovf = 1'b0;
  logic        out_valid;
  logic [4:0]  out_index;
  logic [25:0] out_onehot;
  logic [2:0]  count;
  logic        ovf;

  int checks = 0;
  int failures = 0;

  scan_letter_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .scan_valid(scan_valid),
    .scan_code(scan_code), .out_ready(out_ready), .clr_ovf(clr_ovf),
    .out_valid(out_valid), .out_index(out_index), .out_onehot(out_onehot),
    .count(count), .ovf(ovf)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle strobe; returns at the negedge after the sampling posedge.
  task automatic scan(input logic [7:0] c);
    @(negedge CLOCK_50);
    scan_valid = 1'b1;
    scan_code  = c;
    @(negedge CLOCK_50);
    scan_valid = 1'b0;
  endtask

  task automatic press(input logic [7:0] c);
    scan(c); scan(8'hF0); scan(c);
  endtask

  task automatic pop_chk(input string tag, input logic [4:0] exp_idx);
    @(negedge CLOCK_50);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_idx"}, 32'(out_index), 32'(exp_idx));
    out_ready = 1'b1;
    @(negedge CLOCK_50);
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge CLOCK_50);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_idx", 32'(out_index), 32'd0);
    chk("rst_onehot", 32'(out_onehot), 32'd0);
    resetn = 1'b1;

    // Single press: A visible one cycle after strobe
    scan(8'h1C);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_idx", 32'(out_index), 32'd0);
    chk("single_onehot", 32'(out_onehot), 32'h1);
    chk("single_count", 32'(count), 32'd1);
    scan(8'hF0); scan(8'h1C);
    chk("single_rel_count", 32'(count), 32'd1);
    pop_chk("single_pop", 5'd0);
    chk("single_empty", 32'(count), 32'd0);

    // Typematic: 2D x3, release, 2D x2 -> two entries
    scan(8'h2D); scan(8'h2D); scan(8'h2D); scan(8'hF0); scan(8'h2D); scan(8'h2D);
    chk("typ_count", 32'(count), 32'd2);
    chk("typ_onehot", 32'(out_onehot), 32'h20000);
    pop_chk("typ_pop0", 5'd17);
    pop_chk("typ_pop1", 5'd17);
    chk("typ_empty", 32'(count), 32'd0);
    scan(8'hF0); scan(8'h2D);

    // Extended and non-letter codes produce nothing
    scan(8'hE0); scan(8'h1C);
    scan(8'hE0); scan(8'hF0); scan(8'h1C);
    scan(8'h29);
    chk("ext_count", 32'(count), 32'd0);
    chk("ext_ovf", 32'(ovf), 32'd0);
    scan(8'h35);
    chk("ext_y_count", 32'(count), 32'd1);
    pop_chk("ext_y", 5'd24);
    scan(8'hF0); scan(8'h35);

    // Overflow: A..D fill, E dropped
    press(8'h1C); press(8'h32); press(8'h21); press(8'h23);
    scan(8'h24);
    chk("ovf_count", 32'(count), 32'd4);
    chk("ovf_flag", 32'(ovf), 32'd1);
    chk("ovf_head", 32'(out_index), 32'd0);
    pop_chk("ovf_pop0", 5'd0);
    pop_chk("ovf_pop1", 5'd1);
    pop_chk("ovf_pop2", 5'd2);
    pop_chk("ovf_pop3", 5'd3);
    chk("ovf_drained", 32'(out_valid), 32'd0);
    // Dropped E still became the held key, so its repeat is suppressed
    scan(8'h24);
    chk("ovf_held_rep", 32'(count), 32'd0);
    scan(8'hF0); scan(8'h24);
    chk("ovf_sticky", 32'(ovf), 32'd1);
    @(negedge CLOCK_50); clr_ovf = 1'b1;
    @(negedge CLOCK_50); clr_ovf = 1'b0;
    chk("ovf_clr", 32'(ovf), 32'd0);

    // Full with simultaneous push and pop
    press(8'h1C); press(8'h32); press(8'h21); press(8'h23);
    chk("fpp_full", 32'(count), 32'd4);
    @(negedge CLOCK_50);
    scan_valid = 1'b1; scan_code = 8'h1A; out_ready = 1'b1;
    @(negedge CLOCK_50);
    scan_valid = 1'b0; out_ready = 1'b0;
    chk("fpp_count", 32'(count), 32'd4);
    chk("fpp_ovf", 32'(ovf), 32'd0);
    pop_chk("fpp_pop0", 5'd1);
    pop_chk("fpp_pop1", 5'd2);
    pop_chk("fpp_pop2", 5'd3);
    pop_chk("fpp_pop3", 5'd25);
    chk("fpp_empty", 32'(count), 32'd0);
    scan(8'hF0); scan(8'h1A);

    // Async reset mid-sequence after F0
    press(8'h1C); press(8'h32); press(8'h21);
    scan(8'hF0);
    chk("ar_pre_count", 32'(count), 32'd3);
    #2 resetn = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_count", 32'(count), 32'd0);
    @(negedge CLOCK_50); resetn = 1'b1;
    scan(8'h1C);
    chk("ar_make_count", 32'(count), 32'd1);
    chk("ar_make_idx", 32'(out_index), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/scan_letter_queue.md
Name: scan_letter_queue

Overview:
- Sits between the PS/2 keyboard receiver and the rotor stage.
- Consumes raw scan-code strobes and decodes make/break (F0) and extended (E0) prefixes.
- Suppresses typematic repeats while a key is held.
- Queues one event per letter key-press in a small FIFO with a valid/ready handshake, so the rotor steps exactly once per press. This replaces purely combinational press detection.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- PTR_W, 2, log2(DEPTH); must match DEPTH.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- scan_valid  in  1  one-cycle strobe; scan_code valid this cycle.
- scan_code  in  8  PS/2 set-2 byte.
- out_ready  in  1  consumer accepts the head entry this cycle.
- clr_ovf  in  1  synchronous clear of ovf.
- out_valid  out  1  FIFO non-empty.
- out_index  out  5  head letter, A=0 .. Z=25.
- out_onehot  out  26  head letter one-hot, bit out_index set; all zero when empty.
- count  out  PTR_W+1  current occupancy.
- ovf  out  1  sticky: an event was dropped because the FIFO was full.

Behaviour:
- Reset (async assert, sync release): prefix FSM to IDLE; held_valid=0; FIFO empty.
  - Outputs at reset: out_valid=0, out_index=0, out_onehot=0, count=0, ovf=0.
- Letter table, scan_code A..Z: 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A.
- Prefix FSM advances only on cycles with scan_valid=1:
  - IDLE: E0 -> EXT; F0 -> BRK; letter code -> make event, stay IDLE; other -> IDLE.
  - BRK: any code -> IDLE. If held_valid and code==held_code, clear held_valid.
  - EXT: F0 -> EXTBRK; any other -> IDLE, ignored.
  - EXTBRK: any code -> IDLE, ignored. Extended keys never produce events.
- Make event rules:
  - If held_valid and code==held_code: typematic repeat, suppressed.
  - Otherwise: push the letter index, set held_code=code, held_valid=1.
  - A new key pressed while another is held replaces held_code.
- Push timing:
  - The entry is written on the same edge that samples scan_valid.
  - out_valid/count reflect it the next cycle. Latency from scan_valid to out_valid is 1 cycle when the FIFO is empty.
- Pop: on an edge where out_valid=1 and out_ready=1. out_ready while empty is ignored.
- Outputs out_index/out_onehot are driven combinationally from the head entry.
- Simultaneous push and pop:
  - Both occur and count is unchanged.
  - Holds when full, because the pop frees the slot; no drop and no ovf.
- Full without pop: the push is dropped and ovf sets.
  - held_code is still updated, so the release is tracked correctly.
- ovf clears only on clr_ovf=1 or reset. If a drop and clr_ovf occur in the same cycle, ovf=1 (set wins).
- Pointers wrap modulo DEPTH. count saturates at DEPTH and never exceeds it.
- Reset asserted mid-sequence (e.g. after F0) discards the prefix state and all queued entries.

Optional Feature:
- SCAN_TYPEMATIC_EN
- Defined: repeat suppression is disabled. Every letter make code in IDLE pushes, including auto-repeats, which gives keyboard auto-repeat typing. held_code logic is still present but has no effect on pushes.
- Undefined (default): repeats are suppressed as specified above.

Test Plan:
- Single press: scan 1C then F0,1C; out_ready=0 -> one cycle after the 1C strobe, out_valid=1, out_index=0, out_onehot=26'h1, count=1. The F0,1C pair adds nothing.
- Typematic: scan 2D,2D,2D,F0,2D,2D -> exactly two entries, both index 17; with SCAN_TYPEMATIC_EN defined -> four entries.
- Extended/other: scan E0,1C then E0,F0,1C then 29 -> count stays 0, ovf=0; a following 35 -> index 24.
- Overflow and clear: DEPTH=4, push A,B,C,D,E with releases between, out_ready=0 -> count=4, ovf=1, head=A. Then pop four times -> indices 0,1,2,3, no E. Then clr_ovf -> ovf=0.
- Full with simultaneous push/pop: FIFO full with A..D; scan_valid=1 with 1A and out_ready=1 in the same cycle -> count stays 4, ovf=0, drain order B,C,D,Z.
- Async reset: assert resetn=0 mid-cycle after F0 with 3 entries queued -> out_valid=0, count=0 immediately. After release, scan 1C -> treated as a make (IDLE), pushes index 0.
